// File: rtl/warp_processing_lane.sv
// Single SIMT execution lane: 32x32 register file and a
// decode/execute/writeback sequencer running one ALU op at a time.
module warp_processing_lane #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lane_enable,
    input  logic              execute,
    input  logic [31:0]       instruction,
    output logic              ready,
    output logic              wb_valid,
    output logic [4:0]        wb_dst,
    output logic [DATA_W-1:0] wb_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_MAX = 4'd3,
        OP_MIN = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } opcode_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [4:0]        dst_q;
    logic [4:0]        src1_q;
    logic [4:0]        src2_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic accept;
    logic op_defined;
    logic wr_en;

    assign accept     = (state_q == S_IDLE) && execute && lane_enable;
    assign op_defined = (op_q <= OP_SHR);
    assign wr_en      = (state_q == S_WB) && op_defined && (dst_q != 5'd0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_d = '0;
        case (op_q)
            OP_ADD: result_d = op_a_q + op_b_q;
            OP_SUB: result_d = op_a_q - op_b_q;
            OP_MUL: result_d = op_a_q * op_b_q;
            OP_MAX: result_d = ($signed(op_a_q) > $signed(op_b_q)) ? op_a_q : op_b_q;
            OP_MIN: result_d = ($signed(op_a_q) < $signed(op_b_q)) ? op_a_q : op_b_q;
            OP_AND: result_d = op_a_q & op_b_q;
            OP_OR:  result_d = op_a_q | op_b_q;
            OP_XOR: result_d = op_a_q ^ op_b_q;
            OP_SHL: result_d = op_a_q << op_b_q[4:0];
            OP_SHR: result_d = op_a_q >> op_b_q[4:0];
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= instruction[31:28];
                dst_q  <= instruction[22:18];
                src1_q <= instruction[17:13];
                src2_q <= instruction[12:8];
            end
            // R0 is never written, but force zero on read regardless
            if (state_q == S_DECODE) begin
                op_a_q <= (src1_q == 5'd0) ? '0 : regs_q[src1_q];
                op_b_q <= (src2_q == 5'd0) ? '0 : regs_q[src2_q];
            end
            if (state_q == S_EXEC) begin
                result_q <= result_d;
            end
            if (wr_en) begin
                regs_q[dst_q] <= result_q;
            end
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign wb_valid = (state_q == S_WB) && op_defined;
    assign wb_dst   = dst_q;
    assign wb_data  = result_q;

endmodule

// File: tb/tb_warp_processing_lane.sv
// Directed bench for warp_processing_lane with a reference register
// model and a scoreboard queue of expected writebacks.
module tb_warp_processing_lane;

    logic        clk = 1'b0;
    logic        rst;
    logic        lane_enable;
    logic        execute;
    logic [31:0] instruction;
    logic        ready;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;

    typedef struct {
        logic        valid;
        logic [4:0]  dst;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t     sb[$];
    logic [31:0] mregs [32];
    int          total  = 0;
    int          passed = 0;

    warp_processing_lane dut (
        .clk         (clk),
        .rst         (rst),
        .lane_enable (lane_enable),
        .execute     (execute),
        .instruction (instruction),
        .ready       (ready),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb_;
        logic [63:0] p;
        sa = a;
        sb_ = b;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: begin p = a * b; return p[31:0]; end
            4'd3: return (sa >= sb_) ? a : b;
            4'd4: return (sa <= sb_) ? a : b;
            4'd5: return a & b;
            4'd6: return a | b;
            4'd7: return a ^ b;
            4'd8: return a << b[4:0];
            4'd9: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Push expectation and update model; call at a negedge.
    task automatic push_exp(input logic [3:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2);
        wb_exp_t e;
        logic [31:0] a, b;
        a = (s1 == 0) ? 32'd0 : mregs[s1];
        b = (s2 == 0) ? 32'd0 : mregs[s2];
        e.valid = (op <= 4'd9);
        e.dst   = d;
        e.data  = ref_alu(op, a, b);
        sb.push_back(e);
        if (e.valid && d != 0) mregs[d] = e.data;
    endtask

    // Issue one instruction at a negedge and check it through writeback.
    task automatic run(input string tag, input logic [3:0] op,
                       input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input bit busy_poke);
        wb_exp_t e;
        push_exp(op, d, s1, s2);
        instruction = {op, 5'h1f, d, s1, s2, 8'ha5};
        lane_enable = 1'b1;
        execute     = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        if (busy_poke) begin
            // held execute and dropped enable while busy must not disturb
            instruction = {4'd0, 5'd0, 5'd20, 5'd1, 5'd1, 8'd0};
            lane_enable = 1'b0;
        end else begin
            execute = 1'b0;
        end
        @(posedge clk);
        @(posedge clk); #1;
        execute     = 1'b0;
        lane_enable = 1'b1;
        e = sb.pop_front();
        chk({tag, "_wbv"}, 32'(wb_valid), 32'(e.valid));
        if (e.valid) begin
            chk({tag, "_dst"}, 32'(wb_dst), 32'(e.dst));
            chk({tag, "_data"}, wb_data, e.data);
        end
        @(posedge clk); #1;
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
        chk({tag, "_wbv_off"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        lane_enable = 1'b0;
        execute = 1'b0;
        instruction = '0;
        model_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_dst", 32'(wb_dst), 32'd0);
        chk("rst_data", wb_data, 32'd0);

        run("add", 4'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        run("mul", 4'd2, 5'd4, 5'd5, 5'd6, 1'b0);
        run("max", 4'd3, 5'd7, 5'd8, 5'd9, 1'b0);
        run("add_r0", 4'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        run("rd_r0", 4'd0, 5'd10, 5'd0, 5'd0, 1'b0);
        run("add_self", 4'd0, 5'd5, 5'd5, 5'd5, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("b2b%0d", i), 4'd0, 5'(i), 5'(i + 1),
                5'(i + 2), 1'b0);
        end

        run("sub_neg", 4'd1, 5'd14, 5'd0, 5'd3, 1'b0);
        run("max_sgn", 4'd3, 5'd15, 5'd14, 5'd2, 1'b0);
        run("min_sgn", 4'd4, 5'd16, 5'd14, 5'd2, 1'b0);
        run("and", 4'd5, 5'd17, 5'd14, 5'd13, 1'b0);
        run("or", 4'd6, 5'd18, 5'd12, 5'd11, 1'b0);
        run("xor", 4'd7, 5'd19, 5'd14, 5'd11, 1'b0);
        run("shl", 4'd8, 5'd21, 5'd14, 5'd4, 1'b0);
        run("shr", 4'd9, 5'd22, 5'd14, 5'd4, 1'b0);
        run("mul_wrap", 4'd2, 5'd23, 5'd21, 5'd21, 1'b0);
        run("nop", 4'd12, 5'd24, 5'd1, 5'd2, 1'b0);
        run("nop_chk", 4'd0, 5'd25, 5'd24, 5'd0, 1'b0);
        run("busy_poke", 4'd1, 5'd26, 5'd30, 5'd3, 1'b1);
        run("poke_chk", 4'd6, 5'd27, 5'd20, 5'd26, 1'b0);

        // masked lane ignores execute
        lane_enable = 1'b0;
        execute = 1'b1;
        instruction = {4'd0, 5'd0, 5'd28, 5'd1, 5'd1, 8'd0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mask_rdy%0d", i), 32'(ready), 32'd1);
            chk($sformatf("mask_wbv%0d", i), 32'(wb_valid), 32'd0);
        end
        execute = 1'b0;
        lane_enable = 1'b1;
        @(posedge clk); #1;
        chk("mask_restore", 32'(ready), 32'd1);
        @(negedge clk);
        run("mask_chk", 4'd0, 5'd29, 5'd28, 5'd0, 1'b0);

        // reset mid-instruction aborts the write and restores R[i]=i
        instruction = {4'd1, 5'd0, 5'd12, 5'd0, 5'd1, 8'd0};
        execute = 1'b1;
        @(posedge clk); #1;
        execute = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_wbv", 32'(wb_valid), 32'd0);
        chk("mid_rst_data", wb_data, 32'd0);
        @(negedge clk);
        run("post_rst", 4'd0, 5'd13, 5'd12, 5'd1, 1'b0);

        if (sb.size() != 0) begin
            total++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
